alu_share_arbiter: RTL and testbench

- Shares one 4-bit combinational ALU core between two requesters (port 0, port 1) in the same clock domain.
- Round-robin arbitration; captures the granted requester's operands and opcode, then executes one operation.
- Returns a registered 5-bit result (carry/borrow in bit 4) with a one-cycle done pulse to the owner.
- Sits between the two datapath clients and the ALU, so neither client drives the ALU directly.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_share_arbiter_if.sv | 42 ++++
 rtl/alu4_core.sv | 32 +++
 rtl/alu_share_arbiter.sv | 138 +++++++++++++
 tb/tb_alu_share_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the shared-ALU arbiter: opcode values, FSM state
// encoding and default datapath widths.
package alu_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_OPW   = 4;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_XNOR = 4'd5;
    localparam logic [3:0] OP_NOT  = 4'd6;
    localparam logic [3:0] OP_SHR  = 4'd7;
    localparam logic [3:0] OP_SHL  = 4'd8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Client-facing bundle of the shared-ALU arbiter: two request/operand ports,
// their grant/done/result returns, plus busy and the FSM state for debug.
interface alu_share_arbiter_if import alu_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int OPW   = DEF_OPW
) ();

    // Handshake: reqN is a level held by the client until gntN pulses; the
    // operands are sampled only on the IDLE edge that produces that gntN,
    // and doneN pulses one cycle later with yN/errN valid (held afterwards).
    logic             req0;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic [OPW-1:0]   sel0;
    logic             gnt0;
    logic             done0;
    logic [WIDTH:0]   y0;
    logic             err0;

    logic             req1;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic [OPW-1:0]   sel1;
    logic             gnt1;
    logic             done1;
    logic [WIDTH:0]   y1;
    logic             err1;

    logic             busy;
    state_t           dbg_state;

    modport master (
        output req0, a0, b0, sel0, req1, a1, b1, sel1,
        input  gnt0, done0, y0, err0, gnt1, done1, y1, err1, busy, dbg_state
    );

    modport slave (
        input  req0, a0, b0, sel0, req1, a1, b1, sel1,
        output gnt0, done0, y0, err0, gnt1, done1, y1, err1, busy, dbg_state
    );

endinterface

// File: rtl/alu4_core.sv
// Purely combinational ALU: one operation per opcode, carry/borrow in the
// top result bit, err raised for unassigned opcodes.
module alu4_core import alu_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int OPW   = DEF_OPW
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OPW-1:0]   sel,
    output logic [WIDTH:0]   y,
    output logic             err
);

    always_comb begin
        y   = '0;
        err = 1'b0;
        case (sel)
            OP_ADD:  y = {1'b0, a} + {1'b0, b};
            // Wrapping the extended subtraction leaves the borrow in the top bit.
            OP_SUB:  y = {1'b0, a} - {1'b0, b};
            OP_AND:  y = {1'b0, a & b};
            OP_OR:   y = {1'b0, a | b};
            OP_XOR:  y = {1'b0, a ^ b};
            OP_XNOR: y = {1'b0, ~(a ^ b)};
            OP_NOT:  y = {1'b0, ~a};
            OP_SHR:  y = {1'b0, a >> b};
            OP_SHL:  y = {1'b0, a << b};
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two clients:
// capture on grant, evaluate in EXEC, return the registered result in RESP.
module alu_share_arbiter import alu_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int OPW   = DEF_OPW
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_share_arbiter_if.slave  bus
);

    state_t           state_q, state_d;
    logic             prio_q, prio_d;
    logic             owner_q, owner_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [OPW-1:0]   sel_q, sel_d;
    logic             gnt0_q, gnt0_d;
    logic             gnt1_q, gnt1_d;
    logic             done0_q, done0_d;
    logic             done1_q, done1_d;
    logic [WIDTH:0]   y0_q, y0_d;
    logic [WIDTH:0]   y1_q, y1_d;
    logic             err0_q, err0_d;
    logic             err1_q, err1_d;
    logic             busy_q, busy_d;

    logic [WIDTH:0]   alu_y;
    logic             alu_err;
    logic             winner;

    alu4_core #(.WIDTH(WIDTH), .OPW(OPW)) u_core (
        .a   (a_q),
        .b   (b_q),
        .sel (sel_q),
        .y   (alu_y),
        .err (alu_err)
    );

    // Under contention prio picks the port; a lone requester always wins.
    assign winner = (bus.req0 && bus.req1) ? prio_q : bus.req1;

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        owner_d = owner_q;
        a_d     = a_q;
        b_d     = b_q;
        sel_d   = sel_q;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        done0_d = 1'b0;
        done1_d = 1'b0;
        y0_d    = y0_q;
        y1_d    = y1_q;
        err0_d  = err0_q;
        err1_d  = err1_q;
        case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    owner_d = winner;
                    a_d     = winner ? bus.a1   : bus.a0;
                    b_d     = winner ? bus.b1   : bus.b0;
                    sel_d   = winner ? bus.sel1 : bus.sel0;
                    gnt0_d  = !winner;
                    gnt1_d  = winner;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (owner_q) begin
                    y1_d    = alu_y;
                    err1_d  = alu_err;
                    done1_d = 1'b1;
                end else begin
                    y0_d    = alu_y;
                    err0_d  = alu_err;
                    done0_d = 1'b1;
                end
                state_d = RESP;
            end
            RESP: begin
                prio_d  = !owner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            owner_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sel_q   <= '0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            y0_q    <= '0;
            y1_q    <= '0;
            err0_q  <= 1'b0;
            err1_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            owner_q <= owner_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sel_q   <= sel_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
            y0_q    <= y0_d;
            y1_q    <= y1_d;
            err0_q  <= err0_d;
            err1_q  <= err1_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.gnt0      = gnt0_q;
    assign bus.gnt1      = gnt1_q;
    assign bus.done0     = done0_q;
    assign bus.done1     = done1_q;
    assign bus.y0        = y0_q;
    assign bus.y1        = y1_q;
    assign bus.err0      = err0_q;
    assign bus.err1      = err1_q;
    assign bus.busy      = busy_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: a cycle-scheduled reference model,
// a per-cycle compare, a result scoreboard and hand-computed literals.
module tb_alu_share_arbiter;
  import alu_pkg::*;

  logic clk;
  logic rst_n;
  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  alu_share_arbiter_if bus_if();

  alu_share_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Returns {err, y[4:0]} from the opcode table using plain integer arithmetic.
  function automatic logic [5:0] model_alu(input logic [3:0] a, input logic [3:0] b, input logic [3:0] sel);
    int ia, ib, r;
    bit e;
    ia = int'(a);
    ib = int'(b);
    r = 0;
    e = 0;
    case (int'(sel))
      0: r = ia + ib;
      1: r = ((ia - ib) & 15) + ((ia < ib) ? 16 : 0);
      2: r = ia & ib;
      3: r = ia | ib;
      4: r = ia ^ ib;
      5: r = 15 - (ia ^ ib);
      6: r = 15 - ia;
      7: r = (ib >= 4) ? 0 : (ia >> ib);
      8: r = (ib >= 4) ? 0 : ((ia << ib) & 15);
      default: e = 1;
    endcase
    return {e, r[4:0]};
  endfunction

  // Model schedules each accepted op by cycle number: grant on the acceptance
  // cycle, done/result one cycle later, next acceptance three cycles after.
  int cyc;
  bit op_v;
  int acc_cyc;
  bit m_owner;
  bit m_prio;
  logic [5:0] m_res;
  logic [4:0] e_y0, e_y1;
  logic e_err0, e_err1, e_gnt0, e_gnt1, e_done0, e_done1, e_busy;
  logic [6:0] exp_q[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc = 0; op_v = 0; acc_cyc = 0; m_owner = 0; m_prio = 0; m_res = '0;
      e_y0 = '0; e_y1 = '0; e_err0 = 0; e_err1 = 0;
      e_gnt0 = 0; e_gnt1 = 0; e_done0 = 0; e_done1 = 0; e_busy = 0;
      exp_q.delete();
    end else begin
      cyc++;
      if (op_v && cyc >= acc_cyc + 3) op_v = 0;
      if (!op_v && (bus_if.req0 || bus_if.req1)) begin
        m_owner = (bus_if.req0 && bus_if.req1) ? m_prio : bus_if.req1;
        m_res = m_owner ? model_alu(bus_if.a1, bus_if.b1, bus_if.sel1)
                        : model_alu(bus_if.a0, bus_if.b0, bus_if.sel0);
        m_prio = !m_owner;
        op_v = 1;
        acc_cyc = cyc;
        exp_q.push_back({m_owner, m_res});
      end
      e_gnt0  = op_v && cyc == acc_cyc && !m_owner;
      e_gnt1  = op_v && cyc == acc_cyc && m_owner;
      e_done0 = op_v && cyc == acc_cyc + 1 && !m_owner;
      e_done1 = op_v && cyc == acc_cyc + 1 && m_owner;
      e_busy  = op_v && cyc <= acc_cyc + 1;
      if (e_done0) begin e_y0 = m_res[4:0]; e_err0 = m_res[5]; end
      if (e_done1) begin e_y1 = m_res[4:0]; e_err1 = m_res[5]; end
    end
  end

  // ---------------- per-cycle compare + scoreboard ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      logic [6:0] e;
      check("cyc_gnt0", bus_if.gnt0, e_gnt0);
      check("cyc_gnt1", bus_if.gnt1, e_gnt1);
      check("cyc_done0", bus_if.done0, e_done0);
      check("cyc_done1", bus_if.done1, e_done1);
      check("cyc_busy", bus_if.busy, e_busy);
      check("cyc_y0", bus_if.y0, e_y0);
      check("cyc_y1", bus_if.y1, e_y1);
      check("cyc_err0", bus_if.err0, e_err0);
      check("cyc_err1", bus_if.err1, e_err1);
      if (bus_if.done0 || bus_if.done1) begin
        check("sb_pending", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("sb_owner", bus_if.done1, e[6]);
          check("sb_y", bus_if.done1 ? bus_if.y1 : bus_if.y0, e[4:0]);
          check("sb_err", bus_if.done1 ? bus_if.err1 : bus_if.err0, e[5]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_port(input bit p, input logic r, input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] sel);
    if (p) begin
      bus_if.req1 = r; bus_if.a1 = a; bus_if.b1 = b; bus_if.sel1 = sel;
    end else begin
      bus_if.req0 = r; bus_if.a0 = a; bus_if.b0 = b; bus_if.sel0 = sel;
    end
  endtask

  function automatic logic pulse_of(input int which);
    case (which)
      0: return bus_if.gnt0;
      1: return bus_if.gnt1;
      2: return bus_if.done0;
      default: return bus_if.done1;
    endcase
  endfunction

  task automatic wait_pulse(input string name, input int which);
    bit seen;
    seen = 0;
    for (int n = 0; n < 8 && !seen; n++) begin
      @(negedge clk);
      seen = pulse_of(which);
    end
    check(name, seen, 1);
  endtask

  task automatic single_op(input bit p, input logic [3:0] a, input logic [3:0] b, input logic [3:0] sel,
                           output logic [4:0] y, output logic err);
    set_port(p, 1'b1, a, b, sel);
    wait_pulse("op_gnt_seen", p ? 1 : 0);
    if (p) bus_if.req1 = 1'b0; else bus_if.req0 = 1'b0;
    wait_pulse("op_done_seen", p ? 3 : 2);
    y   = p ? bus_if.y1 : bus_if.y0;
    err = p ? bus_if.err1 : bus_if.err0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    bus_if.req0 = 1'b0;
    bus_if.req1 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- directed tests ----------------
  logic [3:0] ta[5] = '{4'hC, 4'hC, 4'hC, 4'hC, 4'hF};
  logic [3:0] tb[5] = '{4'h5, 4'h5, 4'h5, 4'h0, 4'h1};
  logic [3:0] ts[5] = '{4'd3, 4'd4, 4'd5, 4'd6, 4'd0};
  logic [4:0] ty[5] = '{5'h0D, 5'h09, 5'h06, 5'h03, 5'h10};

  initial begin
    logic [4:0] y;
    logic err;
    int d0, d1, ng;
    int glog[$];

    rst_n = 1'b0;
    set_port(0, 1'b0, '0, '0, '0);
    set_port(1, 1'b0, '0, '0, '0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cmp_en = 1;

    // reset state
    check("rst_busy", bus_if.busy, 0);
    check("rst_y0", bus_if.y0, 0);
    check("rst_y1", bus_if.y1, 0);
    check("rst_state", bus_if.dbg_state, IDLE);

    // lone port 0 add with carry, exact latency
    set_port(0, 1'b1, 4'd9, 4'd8, 4'd0);
    @(negedge clk);
    check("t1_gnt0", bus_if.gnt0, 1);
    check("t1_busy_exec", bus_if.busy, 1);
    bus_if.req0 = 1'b0;
    @(negedge clk);
    check("t1_done0", bus_if.done0, 1);
    check("t1_y0", bus_if.y0, 5'b10001);
    check("t1_err0", bus_if.err0, 0);
    check("t1_busy_resp", bus_if.busy, 1);
    check("t1_y1", bus_if.y1, 0);
    @(negedge clk);
    check("t1_busy_idle", bus_if.busy, 0);

    // simultaneous requests right after reset: port 0 first
    do_reset();
    set_port(0, 1'b1, 4'd3, 4'd5, 4'd1);
    set_port(1, 1'b1, 4'd12, 4'd10, 4'd2);
    d0 = -1; d1 = -1;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (bus_if.gnt0) bus_if.req0 = 1'b0;
      if (bus_if.gnt1) bus_if.req1 = 1'b0;
      if (bus_if.done0) d0 = n;
      if (bus_if.done1) d1 = n;
    end
    check("t2_done0_at", d0, 1);
    check("t2_order", d1 - d0, 3);
    check("t2_y0", bus_if.y0, 5'b11110);
    check("t2_y1", bus_if.y1, 5'b01000);

    // sustained contention: strict alternation
    set_port(0, 1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 8)));
    set_port(1, 1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 8)));
    ng = 0;
    for (int n = 0; n < 40 && ng < 6; n++) begin
      @(negedge clk);
      if (bus_if.gnt0) begin
        glog.push_back(0); ng++;
        set_port(0, 1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      end
      if (bus_if.gnt1) begin
        glog.push_back(1); ng++;
        set_port(1, 1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      end
    end
    bus_if.req0 = 1'b0;
    bus_if.req1 = 1'b0;
    check("t3_grant_count", ng, 6);
    foreach (glog[i]) check($sformatf("t3_grant%0d", i), glog[i], i % 2);
    repeat (3) @(negedge clk);

    // port 1 shifts and illegal opcode
    single_op(1, 4'b1000, 4'd2, 4'd7, y, err);
    check("t4_shr", y, 5'b00010);
    check("t4_shr_err", err, 0);
    single_op(1, 4'b1000, 4'd5, 4'd8, y, err);
    check("t4_shl_big", y, 5'b00000);
    single_op(1, 4'b1000, 4'd5, 4'd12, y, err);
    check("t4_ill_y", y, 5'b00000);
    check("t4_ill_err", err, 1);

    // port 0 logic table
    for (int i = 0; i < 5; i++) begin
      single_op(0, ta[i], tb[i], ts[i], y, err);
      check($sformatf("t4_tab%0d", i), y, ty[i]);
    end

    // operand changes while busy are ignored
    set_port(0, 1'b1, 4'd5, 4'd6, 4'd0);
    wait_pulse("t5_gnt", 0);
    set_port(0, 1'b0, 4'd15, 4'd0, 4'd4);
    wait_pulse("t5_done", 2);
    check("t5_y0", bus_if.y0, 5'b01011);

    // reset during EXEC aborts the op and restores port 0 priority
    @(negedge clk);
    set_port(0, 1'b1, 4'd7, 4'd7, 4'd0);
    wait_pulse("t6_gnt", 0);
    #1 rst_n = 1'b0;
    #1;
    check("t6_busy", bus_if.busy, 0);
    check("t6_done0", bus_if.done0, 0);
    check("t6_y0", bus_if.y0, 0);
    check("t6_y1", bus_if.y1, 0);
    check("t6_state", bus_if.dbg_state, IDLE);
    set_port(1, 1'b1, 4'd2, 4'd3, 4'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_gnt0_first", bus_if.gnt0, 1);
    check("t6_gnt1_later", bus_if.gnt1, 0);
    bus_if.req0 = 1'b0;
    wait_pulse("t6_gnt1", 1);
    bus_if.req1 = 1'b0;
    wait_pulse("t6_done1", 3);
    check("t6_y0_after", bus_if.y0, 5'd14);
    check("t6_y1_after", bus_if.y1, 5'd5);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
